mac_accum: RTL and testbench

MAC_ACCUM -- requirements
Module: mac_accum

---
 rtl/mac_accum.sv | 109 ++++++++++
 tb/tb_mac_accum.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mac_accum.sv
// Multiply-accumulate back end: sums KLEN signed products plus a bias, then
// requantizes (round-half-up, arithmetic shift) and saturates to signed 8 bits.
module mac_accum #(
  parameter int KLEN  = 9,
  parameter int ACC_W = 24,
  parameter int SHIFT = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [15:0]  prod,
  input  logic signed [15:0]  bias,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [7:0]   data_out,
  output logic                sat
);

  localparam int CNT_W = (KLEN > 1) ? $clog2(KLEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KLEN - 1);
  localparam logic signed [ACC_W:0] HALF  = (ACC_W+1)'(1) <<< (SHIFT - 1);
  localparam logic signed [ACC_W:0] MAXV  = (ACC_W+1)'(127);
  localparam logic signed [ACC_W:0] MINV  = (ACC_W+1)'(-128);

  typedef enum logic [1:0] {ACC, ROUND, OUT} state_t;

  state_t                   state_q;
  logic [CNT_W-1:0]         cnt_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_d;
  logic signed [ACC_W:0]    rnd_q;
  logic                     rnd_ph_q;
  logic signed [7:0]        data_q;
  logic                     sat_q;
  logic                     vld_q;

  // One guard bit above the accumulator keeps the rounding add from wrapping.
  function automatic logic signed [ACC_W:0] round_shift(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W:0] t;
    t = (ACC_W+1)'(a) + HALF;
    return t >>> SHIFT;
  endfunction

  // Returns {sat, value} with value clamped to the signed 8-bit range.
  function automatic logic [8:0] sat8(input logic signed [ACC_W:0] r);
    if (r > MAXV)      return {1'b1, 8'h7f};
    else if (r < MINV) return {1'b1, 8'h80};
    else               return {1'b0, r[7:0]};
  endfunction

  always_comb begin
    acc_d = (cnt_q == '0) ? ACC_W'(bias) : acc_q;
    acc_d = acc_d + ACC_W'(prod);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ACC;
      cnt_q    <= '0;
      acc_q    <= '0;
      rnd_q    <= '0;
      rnd_ph_q <= 1'b0;
      data_q   <= '0;
      sat_q    <= 1'b0;
      vld_q    <= 1'b0;
    end else begin
      case (state_q)
        ACC: begin
          if (in_valid) begin
            acc_q <= acc_d;
            if (cnt_q == CNT_LAST) begin
              cnt_q    <= '0;
              rnd_ph_q <= 1'b0;
              state_q  <= ROUND;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        // ROUND spans two cycles: first the rounding shift, then the clamp.
        ROUND: begin
          if (!rnd_ph_q) begin
            rnd_q    <= round_shift(acc_q);
            rnd_ph_q <= 1'b1;
          end else begin
            {sat_q, data_q} <= sat8(rnd_q);
            vld_q    <= 1'b1;
            rnd_ph_q <= 1'b0;
            state_q  <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            vld_q   <= 1'b0;
            state_q <= ACC;
          end
        end
        default: state_q <= ACC;
      endcase
    end
  end

  assign in_ready  = (state_q == ACC);
  assign out_valid = vld_q;
  assign data_out  = data_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_mac_accum.sv
// Directed bench for mac_accum: reset, latency, rounding ties, saturation,
// backpressure and mid-group reset, with hand-computed expected results.
module tb_mac_accum;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] prod;
  logic signed [15:0] bias;
  logic               out_valid;
  logic               out_ready;
  logic signed [7:0]  data_out;
  logic               sat;

  int checks = 0;
  int errors = 0;

  mac_accum #(.KLEN(9), .ACC_W(24), .SHIFT(6)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .prod(prod), .bias(bias), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .sat(sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus only: pushes one 9-beat group, waits for the result, consumes it.
  task automatic run_group(input logic signed [15:0] b, input logic signed [15:0] p[9],
                           output logic signed [7:0] d, output logic s, output int lat);
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; prod = p[i]; bias = b;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = -1;
    d = data_out; s = sat;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; prod = 16'sd1000; bias = 16'sd5;
    repeat (2) begin @(posedge clk); #1; end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
    checks++; if (data_out !== 8'sd0) begin errors++; $display("FAIL reset_data: got %0d, expected 0", data_out); end
    checks++; if (sat !== 1'b0) begin errors++; $display("FAIL reset_sat: got %b, expected 0", sat); end
    in_valid = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready); end
  endtask

  task automatic test_basic();
    logic signed [15:0] p[9];
    logic signed [7:0] d; logic s; int lat;
    foreach (p[i]) p[i] = 16'sd64;
    run_group(16'sd0, p, d, s, lat);
    checks++; if (d !== 8'sd9) begin errors++; $display("FAIL basic_data: got %0d, expected 9", d); end
    checks++; if (s !== 1'b0) begin errors++; $display("FAIL basic_sat: got %b, expected 0", s); end
    checks++; if (lat != 2) begin errors++; $display("FAIL basic_latency: got %0d, expected 2", lat); end
  endtask

  task automatic test_rounding();
    logic signed [15:0] p[9];
    logic signed [7:0] d; logic s; int lat;
    foreach (p[i]) p[i] = 16'sd0;
    p[3] = 16'sd96;
    run_group(16'sd0, p, d, s, lat);
    checks++; if (d !== 8'sd2) begin errors++; $display("FAIL round_pos_tie: got %0d, expected 2", d); end
    p[3] = -16'sd96;
    run_group(16'sd0, p, d, s, lat);
    checks++; if (d !== -8'sd1) begin errors++; $display("FAIL round_neg_tie: got %0d, expected -1", d); end
    p[3] = 16'sd0; p[0] = -16'sd512;
    run_group(16'sd0, p, d, s, lat);
    checks++; if (d !== -8'sd8) begin errors++; $display("FAIL round_neg_exact: got %0d, expected -8", d); end
    checks++; if (s !== 1'b0) begin errors++; $display("FAIL round_sat: got %b, expected 0", s); end
  endtask

  task automatic test_saturation();
    logic signed [15:0] p[9];
    logic signed [7:0] d; logic s; int lat;
    foreach (p[i]) p[i] = 16'sd3584;
    run_group(16'sd0, p, d, s, lat);
    checks++; if (d !== 8'sd127 || s !== 1'b1) begin errors++; $display("FAIL sat_pos: got %0d/%b, expected 127/1", d, s); end
    foreach (p[i]) p[i] = -16'sd1200;
    run_group(16'sd0, p, d, s, lat);
    checks++; if (d !== -8'sd128 || s !== 1'b1) begin errors++; $display("FAIL sat_neg: got %0d/%b, expected -128/1", d, s); end
    foreach (p[i]) p[i] = 16'sd0;
    run_group(16'sd1536, p, d, s, lat);
    checks++; if (d !== 8'sd24 || s !== 1'b0) begin errors++; $display("FAIL bias_only: got %0d/%b, expected 24/0", d, s); end
  endtask

  task automatic test_backpressure();
    logic signed [15:0] p[9];
    logic signed [7:0] d; logic s; int lat;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; prod = 16'sd64; bias = 16'sd0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_timeout: got %b, expected 1", out_valid); end
    in_valid = 1'b1; prod = 16'sd1000; bias = 16'sd1000;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || data_out !== 8'sd9 || sat !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%b d=%0d s=%b rdy=%b, expected v=1 d=9 s=0 rdy=0",
                 c, out_valid, data_out, sat, in_ready);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got v=%b rdy=%b, expected v=0 rdy=1", out_valid, in_ready); end
    // 10 - 576 = -566; (-566 + 32) >>> 6 = -9
    foreach (p[i]) p[i] = -16'sd64;
    run_group(16'sd10, p, d, s, lat);
    checks++; if (d !== -8'sd9 || s !== 1'b0) begin errors++; $display("FAIL bp_next_group: got %0d/%b, expected -9/0", d, s); end
  endtask

  task automatic test_midgroup_reset();
    logic signed [15:0] p[9];
    logic signed [7:0] d; logic s; int lat;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; prod = 16'sd1000; bias = 16'sd0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL midreset_state: got v=%b rdy=%b, expected v=0 rdy=1", out_valid, in_ready); end
    foreach (p[i]) p[i] = 16'sd64;
    run_group(16'sd0, p, d, s, lat);
    checks++; if (d !== 8'sd9 || s !== 1'b0) begin errors++; $display("FAIL midreset_group: got %0d/%b, expected 9/0", d, s); end
    checks++; if (lat != 2) begin errors++; $display("FAIL midreset_latency: got %0d, expected 2", lat); end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; prod = '0; bias = '0;
    #1;
    test_reset();
    test_basic();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_midgroup_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
